core_interface_arbiter: RTL and testbench
=========================================

Name: core_interface_arbiter

Overview:
- Shares one `core_interface` instance between NUM_REQ independent requesters, e.g. the SPI command decoder and a debug/host port.
- Arbitrates round-robin and issues exactly one instruction/address/value transaction to the core per grant.
- Waits a fixed number of cycles, captures `result_i` and returns it to the owning requester.
- Sits between the comms front-ends and `core_interface`; the only block allowed to drive the core's instruction bus.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- RESULT_LATENCY, 2: cycles from the instruction cycle until `core_result_i` is valid (>=1).
- NOP_INSTR, 8'h00: instruction code driven to the core when idle.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active-low
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high
- req_instruction_i  in  NUM_REQ*8  instruction, requester k at bits [8k+7:8k]
- req_address_i  in  NUM_REQ*24  address, packed the same way
- req_value_i  in  NUM_REQ*32  value, packed the same way
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the owner
- rsp_data_o  out  32  captured core result, shared by all requesters
- grant_o  out  NUM_REQ  one-hot owner of the in-flight transaction; 0 when idle
- busy_o  out  1  high in any state other than IDLE
- core_instruction_o  out  8  to `core_interface` `instruction_i`
- core_address_o  out  24  to `core_interface` `address_i`
- core_value_o  out  32  to `core_interface` `value_i`
- core_result_i  in  32  from `core_interface` `result_o`

Behaviour:
- Reset (async assert, sync release) drives these values:
  - state = IDLE, rr pointer = 0;
  - all outputs 0, except core_instruction_o = NOP_INSTR.
- FSM states: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - Combinational round-robin pick among req_valid_i, starting the search at the rr pointer.
  - req_ready_o[winner] = 1 in the same cycle; no valid -> all ready 0.
  - Acceptance = valid & ready at a clock edge: latch instruction/address/value of the winner, set grant_o = winner, go to ISSUE.
  - rr pointer <= (winner+1) mod NUM_REQ.
- ISSUE (cycle T):
  - core_* outputs carry the latched fields for exactly this one cycle.
  - Load wait counter = RESULT_LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - At the edge ending cycle T+RESULT_LATENCY, register core_result_i into rsp_data_o and go to RESPOND.
  - RESULT_LATENCY=1 spends exactly one WAIT cycle.
- RESPOND (cycle T+RESULT_LATENCY+1):
  - rsp_valid_o[owner] = 1 for one cycle; next state IDLE, grant_o = 0.
- Core bus outside ISSUE: core_instruction_o = NOP_INSTR, address/value = 0.
- rsp_data_o holds its value until the next capture.
- Throughput: one transaction per RESULT_LATENCY+3 cycles; no pipelining.
- req_ready_o is 0 for every requester outside IDLE.
- Requests raised during a transaction wait for IDLE. A requester may drop valid before acceptance with no effect.
- A request whose instruction equals NOP_INSTR is accepted and completes normally; the core sees a NOP and the result is still returned.
- Fields are latched at acceptance; requester changes after acceptance are ignored.
- Reset mid-transaction: transaction dropped, no rsp_valid, pointer back to 0.

Optional Feature:
- Macro: CORE_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority; if req_valid_i[0] is high in IDLE it wins regardless of the rr pointer. Other requesters stay round-robin among themselves, and the pointer is not advanced by requester-0 grants.
- Undefined: pure round-robin over all requesters.

Test Plan (NUM_REQ=2, RESULT_LATENCY=2, model core = registered adder: write addr 0/1, read addr 2 returns the sum):
- Reset -> grant_o=0, busy_o=0, core_instruction_o=8'h00, rsp_valid_o=0; assert rst_ni low mid-WAIT -> all return to reset values, no rsp pulse.
- Req0 writes 5 to addr 0, then writes 7 to addr 1, then reads addr 2 -> rsp_data_o=32'd12.
  - rsp_valid_o[0] pulses exactly RESULT_LATENCY+1=3 cycles after the ISSUE cycle.
  - Each transaction takes 5 cycles.
- Req0 and req1 held valid continuously -> grants alternate 0,1,0,1; the core sees exactly one non-NOP instruction per 5 cycles.
- Req1 changes its value from 9 to 3 on the cycle after acceptance -> core_value_o shows 9 in ISSUE.
- Req with instruction 8'h00 -> accepted, rsp_valid pulse still produced, the core bus never shows a non-NOP.
- With CORE_ARB_PRIORITY_EN, both requesters held valid -> req0 granted every transaction, req1 only when req0 is idle.

Source files
------------

// File: rtl/core_interface_arbiter.sv
// core_interface_arbiter
// Shares one core_interface instance between NUM_REQ requesters. A round-robin
// pick in IDLE accepts one request. The request is driven onto the core bus for
// a single ISSUE cycle. The block then waits RESULT_LATENCY cycles, captures
// core_result_i and pulses rsp_valid_o to the owning requester.
// Optional feature: define CORE_ARB_PRIORITY_EN to give requester 0 strict
// priority. The other requesters stay round-robin among themselves.
module core_interface_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          RESULT_LATENCY = 2,
    parameter logic [7:0]  NOP_INSTR      = 8'h00
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*8-1:0]    req_instruction_i,
    input  logic [NUM_REQ*24-1:0]   req_address_i,
    input  logic [NUM_REQ*32-1:0]   req_value_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [31:0]             rsp_data_o,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic                    busy_o,
    output logic [7:0]              core_instruction_o,
    output logic [23:0]             core_address_o,
    output logic [31:0]             core_value_o,
    input  logic [31:0]             core_result_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [7:0]          instr_q;
    logic [23:0]         addr_q;
    logic [31:0]         value_q;
    logic [31:0]         rsp_data_q;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    probe_idx;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic                accept;

    // Round-robin search over the valid requests, starting at the rr pointer
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        probe_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            probe_idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
`ifdef CORE_ARB_PRIORITY_EN
            if (!pick_found && (probe_idx != '0) && req_valid_i[probe_idx]) begin
`else
            if (!pick_found && req_valid_i[probe_idx]) begin
`endif
                pick_found = 1'b1;
                pick_idx   = probe_idx;
            end
        end
`ifdef CORE_ARB_PRIORITY_EN
        if (req_valid_i[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
        pick_onehot = NUM_REQ'(1) << pick_idx;
    end

    // Next-state logic and all externally visible handshake/bus outputs
    always_comb begin
        state_d            = state_q;
        accept             = 1'b0;
        req_ready_o        = '0;
        rsp_valid_o        = '0;
        grant_o            = '0;
        busy_o             = 1'b1;
        core_instruction_o = NOP_INSTR;
        core_address_o     = '0;
        core_value_o       = '0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (pick_found) begin
                    req_ready_o = pick_onehot;
                    accept      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                grant_o            = grant_q;
                core_instruction_o = instr_q;
                core_address_o     = addr_q;
                core_value_o       = value_q;
                state_d            = WAIT;
            end
            WAIT: begin
                grant_o = grant_q;
                if (wait_cnt_q == '0) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                grant_o     = grant_q;
                rsp_valid_o = grant_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; an asserted reset drops any in-flight transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latches the accepted request, advances the pointer, and runs the latency counter and result capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            wait_cnt_q <= '0;
            instr_q    <= '0;
            addr_q     <= '0;
            value_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                instr_q <= req_instruction_i[pick_idx*8 +: 8];
                addr_q  <= req_address_i[pick_idx*24 +: 24];
                value_q <= req_value_i[pick_idx*32 +: 32];
                grant_q <= pick_onehot;
`ifdef CORE_ARB_PRIORITY_EN
                if (pick_idx != '0) begin
                    rr_ptr_q <= IDX_W'((int'(pick_idx) + 1) % NUM_REQ);
                end
`else
                rr_ptr_q <= IDX_W'((int'(pick_idx) + 1) % NUM_REQ);
`endif
            end
            if (state_q == ISSUE) begin
                wait_cnt_q <= CNT_W'(RESULT_LATENCY - 1);
            end else if (state_q == WAIT) begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_q <= wait_cnt_q - 1'b1;
                end else begin
                    rsp_data_q <= core_result_i;
                end
            end
        end
    end

    assign rsp_data_o = rsp_data_q;

endmodule

// File: tb/tb_core_interface_arbiter.sv
// tb_core_interface_arbiter
// Drives core_interface_arbiter (NUM_REQ=2, RESULT_LATENCY=2) against a model core.
// The model core is a registered adder: writes land in addr 0/1, and a read of
// addr 2 returns their sum two cycles later. Expected responses go into a
// scoreboard queue at acceptance and are popped when rsp_valid_o pulses.
module tb_core_interface_arbiter;

    localparam int         NUM_REQ = 2;
    localparam int         LAT     = 2;
    localparam logic [7:0] NOP     = 8'h00;
    localparam logic [7:0] WR      = 8'h01;
    localparam logic [7:0] RD      = 8'h02;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*8-1:0]   req_instruction;
    logic [NUM_REQ*24-1:0]  req_address;
    logic [NUM_REQ*32-1:0]  req_value;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [31:0]            rsp_data;
    logic [NUM_REQ-1:0]     grant;
    logic                   busy;
    logic [7:0]             core_instruction;
    logic [23:0]            core_address;
    logic [31:0]            core_value;
    logic [31:0]            core_result;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          issue_log[$];
    int          owner_log[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          nonnop = 0;
    int          rsp_count = 0;
    int          last_issue = 0;
    logic        busy_prev = 1'b0;
    logic [31:0] shadow0 = 0;
    logic [31:0] shadow1 = 0;
    logic [31:0] core_reg0 = 0;
    logic [31:0] core_reg1 = 0;
    logic [31:0] core_pipe = 0;

    core_interface_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .RESULT_LATENCY (LAT),
        .NOP_INSTR      (NOP)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_instruction_i  (req_instruction),
        .req_address_i      (req_address),
        .req_value_i        (req_value),
        .rsp_valid_o        (rsp_valid),
        .rsp_data_o         (rsp_data),
        .grant_o            (grant),
        .busy_o             (busy),
        .core_instruction_o (core_instruction),
        .core_address_o     (core_address),
        .core_value_o       (core_value),
        .core_result_i      (core_result)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time responses against the ISSUE cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Model core: registered adder with two cycles of result latency
    always @(posedge clk) begin
        if (core_instruction == WR && core_address == 24'd0) core_reg0 <= core_value;
        if (core_instruction == WR && core_address == 24'd1) core_reg1 <= core_value;
        core_pipe   <= (core_instruction == RD && core_address == 24'd2) ? core_reg0 + core_reg1 : 32'h0;
        core_result <= core_pipe;
    end

    // Response monitor: pops the scoreboard on every rsp pulse and checks owner, data and latency
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("[TB] FAIL ready_onehot: req_ready=%b, required at most one bit high", req_ready);
            end
            if (busy && !busy_prev) begin
                last_issue = cyc;
                issue_log.push_back(cyc);
            end
            if (core_instruction != NOP) nonnop++;
            if (rsp_valid != '0) begin
                exp_t e;
                rsp_count++;
                owner_log.push_back(rsp_valid == 2'b10 ? 1 : 0);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: rsp_valid=%b, required no response", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    checks += 2;
                    if (rsp_valid !== (NUM_REQ'(1) << e.owner)) begin
                        errors++;
                        $display("[TB] FAIL rsp_owner: rsp_valid=%b, required owner %0d", rsp_valid, e.owner);
                    end
                    if (rsp_data !== e.data) begin
                        errors++;
                        $display("[TB] FAIL rsp_data: got %0d, required %0d", rsp_data, e.data);
                    end
                    if (cyc - last_issue !== LAT + 1) begin
                        errors++;
                        $display("[TB] FAIL rsp_latency: got %0d cycles after issue, required %0d", cyc - last_issue, LAT + 1);
                    end
                end
            end
            busy_prev = busy;
        end
    end

    // Raises a request for requester k and waits for it to be accepted; hold keeps valid high afterwards
    task automatic drive_req(input int k, input logic [7:0] instr, input logic [23:0] addr,
                             input logic [31:0] val, input bit hold);
        exp_t e;
        bit   done;
        done = 0;
        @(negedge clk);
        req_instruction[k*8 +: 8] = instr;
        req_address[k*24 +: 24]   = addr;
        req_value[k*32 +: 32]     = val;
        req_valid[k]              = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            #1;
            if (req_ready[k]) begin
                e.owner = k;
                e.data  = 32'h0;
                if (instr == WR && addr == 24'd0) shadow0 = val;
                if (instr == WR && addr == 24'd1) shadow1 = val;
                if (instr == RD && addr == 24'd2) e.data = shadow0 + shadow1;
                sb.push_back(e);
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: requester %0d not accepted, required acceptance within 100 cycles", k);
        end
        if (!hold) req_valid[k] = 1'b0;
    endtask

    // Waits for every scoreboard entry to be answered, bounded
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Checks issue spacing in the log is one transaction per LAT+3 cycles
    task automatic check_spacing(input string name);
        for (int i = 1; i < issue_log.size(); i++) begin
            checks++;
            if (issue_log[i] - issue_log[i-1] !== LAT + 3) begin
                errors++;
                $display("[TB] FAIL %s_spacing: issue gap %0d, required %0d", name, issue_log[i] - issue_log[i-1], LAT + 3);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (grant !== '0 || busy !== 1'b0 || core_instruction !== NOP || rsp_valid !== '0 ||
            core_address !== '0 || core_value !== '0 || req_ready !== '0) begin
            errors++;
            $display("[TB] FAIL %s: grant=%b busy=%b instr=%h rsp_valid=%b addr=%h value=%h ready=%b, required all 0 and instr=%h",
                     name, grant, busy, core_instruction, rsp_valid, core_address, core_value, req_ready, NOP);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_instruction = '0;
        req_address = '0;
        req_value = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        checks++;
        if (rsp_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp_data: got %h, required 0", rsp_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("after_release");
    endtask

    task automatic test_adder();
        issue_log.delete();
        drive_req(0, WR, 24'd0, 32'd5, 0);
        drive_req(0, WR, 24'd1, 32'd7, 0);
        drive_req(0, RD, 24'd2, 32'd0, 0);
        drain();
        checks++;
        if (rsp_data !== 32'd12) begin
            errors++;
            $display("[TB] FAIL adder_sum: got %0d, required 12", rsp_data);
        end
        checks++;
        if (issue_log.size() !== 3) begin
            errors++;
            $display("[TB] FAIL adder_issues: got %0d, required 3", issue_log.size());
        end
        check_spacing("adder");
    endtask

    task automatic test_back_to_back();
        int nonnop0;
        nonnop0 = nonnop;
        issue_log.delete();
        owner_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) drive_req(0, RD, 24'd2, 32'd0, i < 3);
            end
            begin
                for (int i = 0; i < 4; i++) drive_req(1, RD, 24'd2, 32'd0, i < 3);
            end
        join
        drain();
        checks++;
        if (owner_log.size() !== 8) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d responses, required 8", owner_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
`ifdef CORE_ARB_PRIORITY_EN
                int exp_owner = (i < 4) ? 0 : 1;
`else
                int exp_owner = (i + 1) % 2;
`endif
                checks++;
                if (owner_log[i] !== exp_owner) begin
                    errors++;
                    $display("[TB] FAIL b2b_owner%0d: got %0d, required %0d", i, owner_log[i], exp_owner);
                end
            end
        end
        checks++;
        if (nonnop - nonnop0 !== 8) begin
            errors++;
            $display("[TB] FAIL b2b_nonnop: got %0d non-NOP cycles, required 8", nonnop - nonnop0);
        end
        check_spacing("b2b");
    endtask

    task automatic test_field_latch();
        drive_req(1, WR, 24'd0, 32'd9, 1);
        req_value[32 +: 32] = 32'd3;
        @(negedge clk);
        checks++;
        if (core_value !== 32'd9 || core_instruction !== WR || core_address !== 24'd0 || grant !== 2'b10) begin
            errors++;
            $display("[TB] FAIL latch_issue: value=%0d instr=%h addr=%0d grant=%b, required 9/%h/0/10",
                     core_value, core_instruction, core_address, grant, WR);
        end
        req_valid[1] = 1'b0;
        drain();
        drive_req(0, RD, 24'd2, 32'd0, 0);
        drain();
        checks++;
        if (rsp_data !== 32'd16) begin
            errors++;
            $display("[TB] FAIL latch_sum: got %0d, required 16", rsp_data);
        end
    endtask

    task automatic test_nop_request();
        int nonnop0;
        int rsp0;
        nonnop0 = nonnop;
        rsp0 = rsp_count;
        drive_req(0, NOP, 24'd1, 32'h1234, 0);
        drain();
        checks += 2;
        if (rsp_count - rsp0 !== 1) begin
            errors++;
            $display("[TB] FAIL nop_rsp: got %0d responses, required 1", rsp_count - rsp0);
        end
        if (nonnop !== nonnop0) begin
            errors++;
            $display("[TB] FAIL nop_bus: got %0d non-NOP cycles, required 0", nonnop - nonnop0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int rsp0;
        drive_req(0, RD, 24'd2, 32'd0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        rsp0 = rsp_count;
        #1;
        check_idle_outputs("mid_wait_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_count !== rsp0) begin
            errors++;
            $display("[TB] FAIL mid_wait_rsp: got %0d responses, required 0", rsp_count - rsp0);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mid_wait_pointer: ready=%b, required 01", req_ready);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        test_reset();
        test_adder();
        test_back_to_back();
        test_field_latch();
        test_nop_request();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
